// File: rtl/rename_sb_pkg.sv
// Shared constants and per-physical-register state for the rename scoreboard.
package rename_sb_pkg;

  localparam int DEF_NUM_REG    = 16;
  localparam int DEF_NUM_TAG    = 8;
  localparam int DEF_NUM_FU     = 4;
  localparam int DEF_REG_BIT    = 16;
  localparam int DEF_RD_CNT_BIT = 2;

  // Storage width for read counters; the active width is RD_CNT_BIT at the top.
  localparam int RD_CNT_MAX_BIT = 8;

  typedef struct packed {
    logic                      write_pending;
    logic                      retired;
    logic [RD_CNT_MAX_BIT-1:0] read_cnt;
  } reg_state_t;

  localparam reg_state_t REG_STATE_RST = '{write_pending: 1'b0, retired: 1'b1, read_cnt: '0};

endpackage

// File: rtl/rename_free_pick.sv
// Lowest-index priority encoder used to pick the next free physical register.
module rename_free_pick #(
  parameter int N       = 16,
  parameter int IDX_BIT = $clog2(N)
) (
  input  logic [N-1:0]       req,
  output logic [IDX_BIT-1:0] idx,
  output logic               found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_BIT'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_scoreboard.sv
// Register rename map plus per-physical-register write/read scoreboard.
// Optional RENAME_SB_BYPASS_EN: operands written back this cycle count as ready.
module rename_scoreboard
  import rename_sb_pkg::*;
#(
  parameter int NUM_REG    = DEF_NUM_REG,
  parameter int NUM_TAG    = DEF_NUM_TAG,
  parameter int NUM_FU     = DEF_NUM_FU,
  parameter int REG_BIT    = DEF_REG_BIT,
  parameter int RD_CNT_BIT = DEF_RD_CNT_BIT,
  parameter int REG_ID_BIT = $clog2(NUM_REG),
  parameter int TAG_ID_BIT = $clog2(NUM_TAG),
  parameter int FU_ID_BIT  = $clog2(NUM_FU)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_FU-1:0]              fu_available,
  input  logic                           issue_vld,
  output logic                           issue_rdy,
  input  logic [FU_ID_BIT-1:0]           issue_fu,
  input  logic [TAG_ID_BIT-1:0]          issue_dst_tag,
  input  logic [TAG_ID_BIT-1:0]          issue_src_tag0,
  input  logic [TAG_ID_BIT-1:0]          issue_src_tag1,
  output logic [REG_ID_BIT-1:0]          issue_dst_phys,
  output logic [REG_ID_BIT-1:0]          issue_src_phys0,
  output logic [REG_ID_BIT-1:0]          issue_src_phys1,
  input  logic [NUM_FU-1:0]              rd_vld,
  output logic [NUM_FU-1:0]              rd_rdy,
  input  logic [NUM_FU*REG_ID_BIT-1:0]   rd_phys0,
  input  logic [NUM_FU*REG_ID_BIT-1:0]   rd_phys1,
  input  logic [NUM_FU*REG_ID_BIT-1:0]   rd_dst_phys,
  output logic [NUM_FU-1:0]              rf_rd_vld,
  input  logic [NUM_FU-1:0]              rf_rd_rdy,
  output logic [NUM_FU*REG_ID_BIT-1:0]   rf_rd_reg0,
  output logic [NUM_FU*REG_ID_BIT-1:0]   rf_rd_reg1,
  input  logic [NUM_FU-1:0]              wb_vld,
  output logic [NUM_FU-1:0]              wb_rdy,
  input  logic [NUM_FU*REG_ID_BIT-1:0]   wb_reg,
  input  logic [NUM_FU*REG_BIT-1:0]      wb_data,
  output logic [NUM_FU-1:0]              rf_wr_vld,
  input  logic [NUM_FU-1:0]              rf_wr_rdy,
  output logic [NUM_FU*REG_ID_BIT-1:0]   rf_wr_reg,
  output logic [NUM_FU*REG_BIT-1:0]      rf_wr_data,
  output logic [NUM_REG-1:0]             reg_write_pending,
  output logic [NUM_REG*RD_CNT_BIT-1:0]  reg_read_cnt
);

  localparam int CNT_MAX = (1 << RD_CNT_BIT) - 1;

  reg_state_t              st_q [NUM_REG];
  reg_state_t              st_d [NUM_REG];
  logic [REG_ID_BIT-1:0]   map_q [NUM_TAG];
  logic [REG_ID_BIT-1:0]   map_d [NUM_TAG];

  logic [REG_ID_BIT-1:0]   rd_phys0_s [NUM_FU];
  logic [REG_ID_BIT-1:0]   rd_phys1_s [NUM_FU];
  logic [REG_ID_BIT-1:0]   rd_dst_s   [NUM_FU];
  logic [REG_ID_BIT-1:0]   wb_reg_s   [NUM_FU];

  logic [NUM_REG-1:0]      free_vec;
  logic [NUM_REG-1:0]      rd_blocked;
  logic [REG_ID_BIT-1:0]   free_idx;
  logic                    free_found;
  logic                    src_cnt_ok;
  logic                    issue_fire;
  logic [NUM_FU-1:0]       ops_ok;
  logic [NUM_FU-1:0]       rd_fire;
  logic [NUM_FU-1:0]       wb_fire;
  logic                    cnt_underflow;
  logic                    dup_write;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
      assign rd_phys0_s[gi] = rd_phys0[gi*REG_ID_BIT +: REG_ID_BIT];
      assign rd_phys1_s[gi] = rd_phys1[gi*REG_ID_BIT +: REG_ID_BIT];
      assign rd_dst_s[gi]   = rd_dst_phys[gi*REG_ID_BIT +: REG_ID_BIT];
      assign wb_reg_s[gi]   = wb_reg[gi*REG_ID_BIT +: REG_ID_BIT];
    end
    for (gi = 0; gi < NUM_REG; gi++) begin : g_reg
      assign reg_write_pending[gi]                        = st_q[gi].write_pending;
      assign reg_read_cnt[gi*RD_CNT_BIT +: RD_CNT_BIT]    = st_q[gi].read_cnt[RD_CNT_BIT-1:0];
      if (gi == 0) begin : g_zero
        assign free_vec[gi] = 1'b0;
      end else begin : g_nz
        assign free_vec[gi] = st_q[gi].retired && !st_q[gi].write_pending && (st_q[gi].read_cnt == '0);
      end
    end
  endgenerate

  rename_free_pick #(.N(NUM_REG), .IDX_BIT(REG_ID_BIT)) u_free_pick (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  // Writeback is a pure pass-through to the register file write port.
  assign wb_rdy     = rf_wr_rdy;
  assign rf_wr_vld  = wb_vld;
  assign rf_wr_reg  = wb_reg;
  assign rf_wr_data = wb_data;
  assign wb_fire    = wb_vld & rf_wr_rdy;

  assign rf_rd_reg0 = rd_phys0;
  assign rf_rd_reg1 = rd_phys1;

  assign issue_src_phys0 = (issue_src_tag0 == '0) ? '0 : map_q[issue_src_tag0];
  assign issue_src_phys1 = (issue_src_tag1 == '0) ? '0 : map_q[issue_src_tag1];
  assign issue_dst_phys  = (issue_dst_tag == '0) ? '0 : free_idx;

  // Increment headroom ignores same-cycle decrements, so a saturated source waits a cycle.
  always_comb begin
    int add0;
    int add1;
    add0 = (issue_src_phys0 == issue_src_phys1) ? 2 : 1;
    add1 = add0;
    src_cnt_ok = 1'b1;
    if (issue_src_phys0 != '0 && (int'(st_q[issue_src_phys0].read_cnt) + add0) > CNT_MAX)
      src_cnt_ok = 1'b0;
    if (issue_src_phys1 != '0 && (int'(st_q[issue_src_phys1].read_cnt) + add1) > CNT_MAX)
      src_cnt_ok = 1'b0;
  end

  assign issue_rdy  = fu_available[issue_fu] && ((issue_dst_tag == '0) || free_found) && src_cnt_ok;
  assign issue_fire = issue_vld && issue_rdy;

`ifdef RENAME_SB_BYPASS_EN
  logic [NUM_REG-1:0] wb_hit;
  always_comb begin
    wb_hit = '0;
    for (int f = 0; f < NUM_FU; f++)
      if (wb_fire[f]) wb_hit[wb_reg_s[f]] = 1'b1;
  end
  always_comb begin
    for (int i = 0; i < NUM_REG; i++)
      rd_blocked[i] = st_q[i].write_pending && !wb_hit[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_REG; i++)
      rd_blocked[i] = st_q[i].write_pending;
  end
`endif

  // An FU's own destination may still be pending; it never blocks its own operand read.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      ops_ok[f] = 1'b1;
      if (rd_phys0_s[f] != '0 && rd_blocked[rd_phys0_s[f]] && rd_phys0_s[f] != rd_dst_s[f])
        ops_ok[f] = 1'b0;
      if (rd_phys1_s[f] != '0 && rd_blocked[rd_phys1_s[f]] && rd_phys1_s[f] != rd_dst_s[f])
        ops_ok[f] = 1'b0;
    end
  end

  assign rd_rdy    = ops_ok & rf_rd_rdy;
  assign rf_rd_vld = ops_ok & rd_vld;
  assign rd_fire   = rd_vld & rd_rdy;

  always_comb begin
    int cnt_tmp;
    logic [REG_ID_BIT-1:0] old_phys;
    map_d         = map_q;
    st_d          = st_q;
    cnt_underflow = 1'b0;
    old_phys      = map_q[issue_dst_tag];
    for (int i = 1; i < NUM_REG; i++) begin
      cnt_tmp = int'(st_q[i].read_cnt);
      if (issue_fire && issue_src_phys0 == REG_ID_BIT'(i)) cnt_tmp = cnt_tmp + 1;
      if (issue_fire && issue_src_phys1 == REG_ID_BIT'(i)) cnt_tmp = cnt_tmp + 1;
      for (int f = 0; f < NUM_FU; f++) begin
        if (rd_fire[f] && rd_phys0_s[f] == REG_ID_BIT'(i)) cnt_tmp = cnt_tmp - 1;
        if (rd_fire[f] && rd_phys1_s[f] == REG_ID_BIT'(i)) cnt_tmp = cnt_tmp - 1;
      end
      if (cnt_tmp < 0) begin
        cnt_underflow = 1'b1;
        cnt_tmp       = 0;
      end
      st_d[i].read_cnt = RD_CNT_MAX_BIT'(cnt_tmp);
    end
    for (int f = 0; f < NUM_FU; f++)
      if (wb_fire[f]) st_d[wb_reg_s[f]].write_pending = 1'b0;
    // Allocation is applied after writeback so it wins on a same-register collision.
    if (issue_fire && issue_dst_tag != '0) begin
      if (old_phys != free_idx) st_d[old_phys].retired = 1'b1;
      st_d[free_idx].write_pending = 1'b1;
      st_d[free_idx].retired       = 1'b0;
      map_d[issue_dst_tag]         = free_idx;
    end
    st_d[0] = REG_STATE_RST;
  end

  always_comb begin
    dup_write = 1'b0;
    for (int f = 0; f < NUM_FU; f++)
      for (int g = f + 1; g < NUM_FU; g++)
        if (wb_fire[f] && wb_fire[g] && wb_reg_s[f] == wb_reg_s[g]) dup_write = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) st_q[i] <= REG_STATE_RST;
      for (int t = 0; t < NUM_TAG; t++) map_q[t] <= '0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) st_q[i] <= st_d[i];
      for (int t = 0; t < NUM_TAG; t++) map_q[t] <= map_d[t];
    end
  end

  a_no_dup_write: assert property (@(posedge clk) disable iff (!rst_n) !dup_write);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !cnt_underflow);

endmodule

// File: tb/tb_rename_scoreboard.sv
// Directed self-checking bench for rename_scoreboard (default parameters).
module tb_rename_scoreboard;

  localparam int NUM_REG = 16, NUM_FU = 4, RB = 4, TB = 3, FB = 2, DB = 16, CB = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_FU-1:0]      fu_available;
  logic                   issue_vld, issue_rdy;
  logic [FB-1:0]          issue_fu;
  logic [TB-1:0]          issue_dst_tag, issue_src_tag0, issue_src_tag1;
  logic [RB-1:0]          issue_dst_phys, issue_src_phys0, issue_src_phys1;
  logic [NUM_FU-1:0]      rd_vld, rd_rdy, rf_rd_vld, rf_rd_rdy;
  logic [NUM_FU*RB-1:0]   rd_phys0, rd_phys1, rd_dst_phys, rf_rd_reg0, rf_rd_reg1;
  logic [NUM_FU-1:0]      wb_vld, wb_rdy, rf_wr_vld, rf_wr_rdy;
  logic [NUM_FU*RB-1:0]   wb_reg, rf_wr_reg;
  logic [NUM_FU*DB-1:0]   wb_data, rf_wr_data;
  logic [NUM_REG-1:0]     reg_write_pending;
  logic [NUM_REG*CB-1:0]  reg_read_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rename_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .fu_available(fu_available),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_fu(issue_fu),
    .issue_dst_tag(issue_dst_tag), .issue_src_tag0(issue_src_tag0), .issue_src_tag1(issue_src_tag1),
    .issue_dst_phys(issue_dst_phys), .issue_src_phys0(issue_src_phys0), .issue_src_phys1(issue_src_phys1),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_phys0(rd_phys0), .rd_phys1(rd_phys1), .rd_dst_phys(rd_dst_phys),
    .rf_rd_vld(rf_rd_vld), .rf_rd_rdy(rf_rd_rdy), .rf_rd_reg0(rf_rd_reg0), .rf_rd_reg1(rf_rd_reg1),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_wr_vld(rf_wr_vld), .rf_wr_rdy(rf_wr_rdy), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .reg_write_pending(reg_write_pending), .reg_read_cnt(reg_read_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic vld, input logic [TB-1:0] dst, input logic [TB-1:0] s0,
                           input logic [TB-1:0] s1);
    issue_vld = vld; issue_fu = '0; issue_dst_tag = dst; issue_src_tag0 = s0; issue_src_tag1 = s1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fu_available = '1; rf_rd_rdy = '1; rf_wr_rdy = '1;
    issue_vld = 0; issue_fu = 0; issue_dst_tag = 0; issue_src_tag0 = 0; issue_src_tag1 = 0;
    rd_vld = 0; rd_phys0 = 0; rd_phys1 = 0; rd_dst_phys = 0;
    wb_vld = 0; wb_reg = 0; wb_data = 0;
    tick(); tick();

    // reset state
    check("rst_wp", reg_write_pending, 0);
    check("rst_cnt", reg_read_cnt, 0);
    check("rst_rdy", issue_rdy, 1);
    fu_available = 4'b1110; #1;
    check("fu_unavail_rdy", issue_rdy, 0);
    fu_available = '1;
    rst_n = 1'b1; tick();
    $display("reset done");

    // first allocation
    set_issue(1, 3, 0, 0);
    check("alloc1_rdy", issue_rdy, 1);
    check("alloc1_phys", issue_dst_phys, 1);
    tick(); set_issue(0, 0, 0, 0);
    check("alloc1_wp", reg_write_pending, 16'h0002);
    $display("issue dst=3 -> phys1");

    // rename of same tag
    set_issue(1, 3, 3, 0);
    check("map3_src", issue_src_phys0, 1);
    issue_src_tag0 = 0; #1;
    check("alloc2_phys", issue_dst_phys, 2);
    tick(); set_issue(0, 0, 0, 0);
    check("alloc2_wp", reg_write_pending, 16'h0006);

    // writeback frees the retired register
    wb_vld[1] = 1'b1; wb_reg[1*RB +: RB] = 4'd1; wb_data[1*DB +: DB] = 16'hBEEF; #1;
    check("wb_rdy", wb_rdy, 4'hF);
    check("wb_pass_vld", rf_wr_vld, 4'b0010);
    check("wb_pass_reg", rf_wr_reg[1*RB +: RB], 1);
    check("wb_pass_data", rf_wr_data[1*DB +: DB], 16'hBEEF);
    tick(); wb_vld = 0;
    check("wb1_wp", reg_write_pending, 16'h0004);
    set_issue(1, 4, 0, 0);
    check("realloc_phys1", issue_dst_phys, 1);
    tick(); set_issue(0, 0, 0, 0);
    check("realloc_wp", reg_write_pending, 16'h0006);
    $display("issue dst=3 twice, writeback phys1, reuse phys1");

    // identical sources add two
    set_issue(1, 0, 4, 4);
    check("dup_src0", issue_src_phys0, 1);
    check("dup_src1", issue_src_phys1, 1);
    check("dup_dst0", issue_dst_phys, 0);
    tick(); set_issue(0, 0, 0, 0);
    check("dup_cnt2", reg_read_cnt, 32'h0000_0008);

    // read vs same-cycle writeback of its operand
    rd_vld[0] = 1'b1; rd_phys0[0 +: RB] = 4'd1; rd_phys1[0 +: RB] = 4'd1; rd_dst_phys[0 +: RB] = 4'd0; #1;
    check("rd_pending_blk", rd_rdy[0], 0);
    wb_vld[1] = 1'b1; wb_reg[1*RB +: RB] = 4'd1; #1;
`ifdef RENAME_SB_BYPASS_EN
    check("rd_bypass_rdy", rd_rdy[0], 1);
    tick(); wb_vld = 0; rd_vld = 0; #1;
`else
    check("rd_nobypass_rdy", rd_rdy[0], 0);
    check("rd_nobypass_rfvld", rf_rd_vld[0], 0);
    tick(); wb_vld = 0;
    rf_rd_rdy[0] = 1'b0; #1;
    check("rd_rf_gate_rdy", rd_rdy[0], 0);
    check("rd_rf_gate_vld", rf_rd_vld[0], 1);
    rf_rd_rdy[0] = 1'b1; #1;
    check("rd_next_rdy", rd_rdy[0], 1);
    check("rd_pass_reg0", rf_rd_reg0[0 +: RB], 1);
    tick(); rd_vld = 0;
`endif
    check("rd_cnt0", reg_read_cnt, 0);
    check("rd_wp", reg_write_pending, 16'h0004);
    $display("read of phys1 against writeback");

    // counter saturation
    set_issue(1, 0, 4, 4); tick();
    set_issue(1, 0, 4, 0); tick(); set_issue(0, 0, 0, 0);
    check("sat_cnt3", reg_read_cnt, 32'h0000_000C);
    set_issue(1, 0, 4, 0);
    check("sat_blk", issue_rdy, 0);
    issue_src_tag0 = 3; #1;
    check("sat_other_ok", issue_rdy, 1);
    issue_src_tag0 = 4;
    rd_vld[2] = 1'b1; rd_phys0[2*RB +: RB] = 4'd1; rd_phys1[2*RB +: RB] = 4'd0; rd_dst_phys[2*RB +: RB] = 4'd0; #1;
    check("sat_rd_rdy", rd_rdy[2], 1);
    check("sat_same_cycle_blk", issue_rdy, 0);
    tick(); rd_vld = 0; #1;
    check("sat_cnt2", reg_read_cnt, 32'h0000_0008);
    check("sat_release", issue_rdy, 1);
    set_issue(0, 0, 0, 0);
    rd_vld[2] = 1'b1; rd_phys1[2*RB +: RB] = 4'd1; tick(); rd_vld = 0;
    check("sat_drain", reg_read_cnt, 0);
    $display("source counter saturation");

    // fill the register file
    for (int i = 0; i < 13; i++) begin
      set_issue(1, 5, 0, 0);
      check($sformatf("fill_rdy_%0d", i), issue_rdy, 1);
      check($sformatf("fill_phys_%0d", i), issue_dst_phys, 3 + i);
      tick();
    end
    set_issue(1, 5, 0, 0);
    check("full_blk", issue_rdy, 0);
    issue_dst_tag = 0; #1;
    check("full_dst0_ok", issue_rdy, 1);
    set_issue(0, 0, 0, 0);
    check("full_wp", reg_write_pending, 16'hFFFC);
    wb_vld[0] = 1'b1; wb_reg[0 +: RB] = 4'd15; tick(); wb_vld = 0;
    set_issue(0, 5, 0, 0);
    check("wb_unretired_blk", issue_rdy, 0);
    wb_vld[0] = 1'b1; wb_reg[0 +: RB] = 4'd14; tick(); wb_vld = 0;
    set_issue(1, 6, 0, 0);
    check("wb_retired_free", issue_rdy, 1);
    check("wb_retired_phys", issue_dst_phys, 14);
    wb_vld[3] = 1'b1; wb_reg[3*RB +: RB] = 4'd14;
    tick(); wb_vld = 0; set_issue(0, 0, 0, 0);
    check("alloc_wins_wb", reg_write_pending, 16'h7FFC);
    $display("fill and drain");

    // reset mid-operation
    set_issue(1, 0, 4, 4);
    rst_n = 1'b0; tick(); rst_n = 1'b1; set_issue(0, 0, 0, 0);
    check("mid_rst_wp", reg_write_pending, 0);
    check("mid_rst_cnt", reg_read_cnt, 0);
    set_issue(0, 3, 6, 0);
    check("mid_rst_map", issue_src_phys0, 0);
    check("mid_rst_phys", issue_dst_phys, 1);
    set_issue(0, 0, 0, 0);
    $display("mid-operation reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
